// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, exception cause
// codes, default exception vector and the redirect-target selection helper.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  localparam logic [31:0] CAUSE_INT     = 32'h0000_0001;
  localparam logic [31:0] CAUSE_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] CAUSE_INST    = 32'h0000_000a;
  localparam logic [31:0] CAUSE_OV      = 32'h0000_000c;
  localparam logic [31:0] CAUSE_TRAP    = 32'h0000_000d;
  localparam logic [31:0] CAUSE_ERET    = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // eret resumes at EPC; every other nonzero cause enters the exception vector.
  function automatic logic [31:0] exc_target(input logic [31:0] cause,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector);
    logic [31:0] tgt;
    case (cause)
      CAUSE_ERET:                                                  tgt = epc;
      CAUSE_INT, CAUSE_SYSCALL, CAUSE_INST, CAUSE_OV, CAUSE_TRAP: tgt = vector;
      default:                                                     tgt = vector;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// Priority encoder: the highest requesting stage freezes itself and every
// stage below it.
module pipe_ctrl_stall_enc #(
  parameter int NUM_STAGES = 6
) (
  input  logic [NUM_STAGES-1:0] stallreq_i,
  output logic [NUM_STAGES-1:0] stall_mask
);

  logic acc;

  always_comb begin
    stall_mask = '0;
    acc        = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc           = acc | stallreq_i[i];
      stall_mask[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception redirect.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WDOG_EN.
//
//   state    | meaning
//   ST_IDLE  | normal operation; stall from encoder, exception detect
//   ST_FLUSH | flush asserted, new_pc driven, counting FLUSH_CYCLES
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          NUM_STAGES   = 6,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          WDOG_LIMIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic [31:0]           excepttype_i,
  input  logic [31:0]           cp0_epc_i,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic                  busy,
  output logic                  wdog_timeout
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  ctrl_state_e           state_q, state_d;
  logic [3:0]            flush_cnt_q, flush_cnt_d;
  logic [31:0]           target_q, target_d;
  logic [NUM_STAGES-1:0] enc_mask;

  pipe_ctrl_stall_enc #(.NUM_STAGES(NUM_STAGES)) u_stall_enc (
    .stallreq_i (stallreq_i),
    .stall_mask (enc_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      target_q    <= target_d;
    end
  end

  // Outputs are gated by rst so they read zero during reset regardless of inputs.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    target_d    = target_q;
    stall       = '0;
    flush       = 1'b0;
    new_pc      = '0;
    busy        = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (excepttype_i != '0) begin
            stall       = '1;
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LAST;
            target_d    = exc_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
          end else begin
            stall = enc_mask;
          end
        end
        ST_FLUSH: begin
          flush  = 1'b1;
          new_pc = target_q;
          busy   = 1'b1;
          if (flush_cnt_q == '0) state_d = ST_IDLE;
          else                   flush_cnt_d = flush_cnt_q - 4'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_WDOG_EN
  logic [15:0] wdog_cnt_q;
  logic        wdog_hit;

  assign wdog_hit = !rst && (state_q == ST_IDLE) && (stall != '0) &&
                    (wdog_cnt_q == 16'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst)                                                   wdog_cnt_q <= '0;
    else if (state_q != ST_IDLE || stall == '0 || wdog_hit)    wdog_cnt_q <= '0;
    else                                                       wdog_cnt_q <= wdog_cnt_q + 16'd1;
  end

  assign wdog_timeout = wdog_hit;
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (1 and 3 flush cycles)
// share stimulus; a behavioural model checks every cycle.
module tb_pipe_ctrl;

  localparam int N = 6;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef PIPE_CTRL_STALL_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  stallreq_i;
  logic [31:0]   excepttype_i, cp0_epc_i;
  logic [N-1:0]  stall_o  [2];
  logic          flush_o  [2];
  logic [31:0]   new_pc_o [2];
  logic          busy_o   [2];
  logic          wdog_o   [2];

  always #5 clk = ~clk;

  pipe_ctrl #(.NUM_STAGES(N), .EXC_VECTOR(VEC), .FLUSH_CYCLES(1), .WDOG_LIMIT(255)) dut_a (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
    .cp0_epc_i(cp0_epc_i), .stall(stall_o[0]), .flush(flush_o[0]),
    .new_pc(new_pc_o[0]), .busy(busy_o[0]), .wdog_timeout(wdog_o[0]));

  pipe_ctrl #(.NUM_STAGES(N), .EXC_VECTOR(VEC), .FLUSH_CYCLES(3), .WDOG_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
    .cp0_epc_i(cp0_epc_i), .stall(stall_o[1]), .flush(flush_o[1]),
    .new_pc(new_pc_o[1]), .busy(busy_o[1]), .wdog_timeout(wdog_o[1]));

  int n_chk = 0;
  int n_pass = 0;

  // Model: remaining flush cycles, latched target, consecutive stall run.
  int          fc  [2] = '{1, 3};
  int          lim [2] = '{255, 4};
  int          rem [2];
  logic [31:0] tgt [2];
  int          run [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] hi_mask(input logic [N-1:0] r);
    int m;
    if (r == '0) return '0;
    m = 0;
    for (int i = 0; i < N; i++) if (r[i]) m = i;
    return N'((1 << (m + 1)) - 1);
  endfunction

  function automatic logic [N-1:0] m_stall(input int d);
    if (rst || rem[d] > 0) return '0;
    if (excepttype_i != 0) return '1;
    return hi_mask(stallreq_i);
  endfunction

  function automatic logic m_wdog(input int d);
    return WDOG_EN && !rst && rem[d] == 0 && m_stall(d) != '0 && (run[d] + 1 == lim[d]);
  endfunction

  task automatic model_check();
    for (int d = 0; d < 2; d++) begin
      logic infl;
      infl = !rst && rem[d] > 0;
      chk($sformatf("stall[%0d]", d), 32'(stall_o[d]), 32'(m_stall(d)));
      chk($sformatf("flush[%0d]", d), 32'(flush_o[d]), 32'(infl));
      chk($sformatf("new_pc[%0d]", d), new_pc_o[d], infl ? tgt[d] : 32'h0);
      chk($sformatf("busy[%0d]", d), 32'(busy_o[d]), 32'(infl));
      chk($sformatf("wdog[%0d]", d), 32'(wdog_o[d]), 32'(m_wdog(d)));
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] s;
      logic         w;
      s = m_stall(d);
      w = m_wdog(d);
      if (rst) begin
        rem[d] = 0; tgt[d] = 0; run[d] = 0;
      end else if (rem[d] > 0) begin
        rem[d]--; run[d] = 0;
      end else begin
        if (s == '0 || w) run[d] = 0;
        else              run[d]++;
        if (excepttype_i != 0) begin
          rem[d] = fc[d];
          tgt[d] = (excepttype_i == 32'he) ? cp0_epc_i : VEC;
        end
      end
    end
  endtask

  // Apply inputs, then sample and model-check at the falling edge.
  task automatic cyc(input logic r, input logic [N-1:0] q, input logic [31:0] e,
                     input logic [31:0] p);
    rst = r; stallreq_i = q; excepttype_i = e; cp0_epc_i = p;
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r; logic [N-1:0] q; logic [31:0] e; logic [31:0] p;
    logic [N-1:0] x_stall; logic x_flush; logic [31:0] x_pc; logic x_busy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 6'b111111, 32'h8, 32'h5,         6'b000000, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 6'b001000, 32'h0, 32'h0,         6'b001111, 1'b0, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 6'b000000, 32'h0, 32'h0,         6'b000000, 1'b0, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 6'b000001, 32'h0, 32'h0,         6'b000001, 1'b0, 32'h0,         1'b0};
    tbl[4]  = '{1'b0, 6'b100000, 32'h0, 32'h0,         6'b111111, 1'b0, 32'h0,         1'b0};
    tbl[5]  = '{1'b0, 6'b010000, 32'h8, 32'h0,         6'b111111, 1'b0, 32'h0,         1'b0};
    tbl[6]  = '{1'b0, 6'b000000, 32'h0, 32'h0,         6'b000000, 1'b1, 32'hBFC0_0380, 1'b1};
    tbl[7]  = '{1'b0, 6'b000000, 32'h0, 32'h0,         6'b000000, 1'b0, 32'h0,         1'b0};
    tbl[8]  = '{1'b0, 6'b000000, 32'he, 32'h0000_1234, 6'b111111, 1'b0, 32'h0,         1'b0};
    tbl[9]  = '{1'b0, 6'b000010, 32'h0, 32'h0,         6'b000000, 1'b1, 32'h0000_1234, 1'b1};
    tbl[10] = '{1'b0, 6'b000010, 32'h0, 32'h0,         6'b000011, 1'b0, 32'h0,         1'b0};

    rst = 1'b1; stallreq_i = '0; excepttype_i = '0; cp0_epc_i = '0;
    for (int d = 0; d < 2; d++) begin rem[d] = 0; tgt[d] = 0; run[d] = 0; end
    @(posedge clk); #1;

    // Table vectors, expectations for the single-flush-cycle instance.
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].r, tbl[i].q, tbl[i].e, tbl[i].p);
      chk($sformatf("tbl%0d.stall", i), 32'(stall_o[0]), 32'(tbl[i].x_stall));
      chk($sformatf("tbl%0d.flush", i), 32'(flush_o[0]), 32'(tbl[i].x_flush));
      chk($sformatf("tbl%0d.new_pc", i), new_pc_o[0], tbl[i].x_pc);
      chk($sformatf("tbl%0d.busy", i), 32'(busy_o[0]), 32'(tbl[i].x_busy));
      adv();
    end

    // eret: EPC latched at detect, held for 3 flush cycles after EPC changes.
    cyc(1, '0, 0, 0); adv();
    cyc(0, '0, 32'he, 32'h8000_1234); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0, 0);
      chk($sformatf("eret.flush%0d", i), 32'(flush_o[1]), 32'h1);
      chk($sformatf("eret.pc%0d", i), new_pc_o[1], 32'h8000_1234);
      adv();
    end
    cyc(0, '0, 0, 0); chk("eret.end", 32'(flush_o[1]), 32'h0); adv();

    // Cause raised during flush and dropped before it ends is ignored.
    cyc(0, '0, 32'h1, 32'h0); adv();
    cyc(0, '0, 32'ha, 32'h0); chk("ign.pc1", new_pc_o[1], VEC); adv();
    cyc(0, '0, 32'ha, 32'h0); chk("ign.pc2", new_pc_o[1], VEC); adv();
    cyc(0, '0, 32'h0, 32'h0); chk("ign.pc3", new_pc_o[1], VEC); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0, 0); chk($sformatf("ign.noflush%0d", i), 32'(flush_o[1]), 32'h0); adv();
    end

    // Reset in flush cycle 2 of 3 aborts the flush.
    cyc(0, '0, 32'hc, 32'h0); adv();
    cyc(0, '0, 0, 0); chk("rstf.c1", 32'(flush_o[1]), 32'h1); adv();
    cyc(1, 6'b111111, 32'hd, 32'h0); chk("rstf.in_rst", 32'(flush_o[1]), 32'h0); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0, 0);
      chk($sformatf("rstf.flush%0d", i), 32'(flush_o[1]), 32'h0);
      chk($sformatf("rstf.busy%0d", i), 32'(busy_o[1]), 32'h0);
      adv();
    end

    // Watchdog on held stall: pulses in stall cycles 4 and 8 only (when enabled).
    cyc(1, '0, 0, 0); adv();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 6'b000100, 0, 0);
      chk($sformatf("wdog.c%0d", i + 1), 32'(wdog_o[1]), 32'(WDOG_EN && (i == 3 || i == 7)));
      adv();
    end

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] e;
      logic [N-1:0] q;
      case ($urandom_range(0, 19))
        0: e = 32'h1; 1: e = 32'h8; 2: e = 32'he; 3: e = $urandom;
        default: e = 32'h0;
      endcase
      q = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 3) == 0) q = 6'b000001;
      cyc($urandom_range(0, 49) == 0, q, e, $urandom);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
